// File: rtl/lzrw1_pkg.sv
// Shared LZRW1 types and constants for the sequencer and the decompressor.
package lzrw1_pkg;

  localparam int ITEMS_PER_GROUP = 16;

  localparam logic FLAG_LITERAL = 1'b0;
  localparam logic FLAG_COPY    = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL_LO,
    S_CTRL_HI,
    S_ITEM_A,
    S_ITEM_B,
    S_ISSUE,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic        flag;
    logic [15:0] data;
  } item_t;

  // Decompressor FSM states, kept here so both blocks share one definition.
  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_LITERAL,
    DEC_COPY_SETUP,
    DEC_COPY
  } dec_state_t;

endpackage

// File: rtl/lzrw1_flag_shifter.sv
// Holds the 16-bit LZRW1 control word and the item counter of the current group.
module lzrw1_flag_shifter
  import lzrw1_pkg::*;
#(
  parameter int ITEMS = ITEMS_PER_GROUP
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       load_lo_i,
  input  logic       load_hi_i,
  input  logic [7:0] byte_i,
  input  logic       shift_i,
  output logic       flag_o,
  output logic       wrap_o
);

  localparam int CW = $clog2(ITEMS);

  logic [15:0]   flags_q, flags_d;
  logic [CW-1:0] count_q, count_d;

  // NOTE: every signal gets its default before any branch, so no path infers a latch.
  always_comb begin
    flags_d = flags_q;
    count_d = count_q;
    if (clear_i)   count_d = '0;
    if (load_lo_i) flags_d[7:0]  = byte_i;
    if (load_hi_i) flags_d[15:8] = byte_i;
    if (shift_i) begin
      flags_d = flags_q >> 1;
      count_d = count_q + CW'(1);
    end
  end

  // NOTE: non-blocking assignments, so each register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      flags_q <= '0;
      count_q <= '0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
    end
  end

  assign flag_o = flags_q[0];
  assign wrap_o = (count_q == CW'(ITEMS - 1));

endmodule

// File: rtl/decompressor_sequencer.sv
// Splits a raw LZRW1 byte stream into literal/copy items for decompressor_top.
module decompressor_sequencer #(
  parameter int ITEMS_PER_GROUP = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] dec_data_in,
  output logic        dec_control_word,
  output logic        dec_in_data_valid,
  input  logic        dec_busy,
  output logic        seq_busy,
  output logic        done,
  output logic        error
);

  import lzrw1_pkg::*;

  seq_state_t  state_q, state_d;
  item_t       item_q, item_d;
  logic [7:0]  hi_q, hi_d;
  logic        error_q, error_d;
  logic        last_q, last_d;
  logic        valid_q, done_q, busy_q;
  logic        clear, load_lo, load_hi, shift, flag, wrap;

  lzrw1_flag_shifter #(.ITEMS(ITEMS_PER_GROUP)) u_flags (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (clear),
    .load_lo_i (load_lo),
    .load_hi_i (load_hi),
    .byte_i    (in_byte),
    .shift_i   (shift),
    .flag_o    (flag),
    .wrap_o    (wrap)
  );

  assign in_ready = (state_q == S_CTRL_LO) || (state_q == S_CTRL_HI) ||
                    (state_q == S_ITEM_A)  || (state_q == S_ITEM_B);

  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    hi_d    = hi_q;
    error_d = error_q;
    last_d  = last_q;
    clear   = 1'b0;
    load_lo = 1'b0;
    load_hi = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CTRL_LO;
        error_d = 1'b0;
        last_d  = 1'b0;
        clear   = 1'b1;
      end
      S_CTRL_LO: if (in_valid) begin
        load_lo = 1'b1;
        state_d = in_last ? S_DONE : S_CTRL_HI;
      end
      S_CTRL_HI: if (in_valid) begin
        load_hi = 1'b1;
        state_d = in_last ? S_DONE : S_ITEM_A;
      end
      S_ITEM_A: if (in_valid) begin
        if (flag == FLAG_COPY) begin
          // A copy needs two bytes; ending on the first one is a malformed stream.
          if (in_last) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            hi_d    = in_byte;
            state_d = S_ITEM_B;
          end
        end else begin
          item_d  = '{flag: FLAG_LITERAL, data: {8'h00, in_byte}};
          last_d  = in_last;
          state_d = S_ISSUE;
        end
      end
      S_ITEM_B: if (in_valid) begin
        item_d  = '{flag: FLAG_COPY, data: {hi_q, in_byte}};
        last_d  = in_last;
        state_d = S_ISSUE;
      end
      S_ISSUE: if (!dec_busy) begin
        shift = 1'b1;
        if (last_q)    state_d = S_DONE;
        else if (wrap) state_d = S_CTRL_LO;
        else           state_d = S_ITEM_A;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      item_q  <= '0;
      hi_q    <= '0;
      error_q <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      hi_q    <= hi_d;
      error_q <= error_d;
      last_q  <= last_d;
      valid_q <= (state_d == S_ISSUE);
      done_q  <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign dec_data_in       = item_q.data;
  assign dec_control_word  = item_q.flag;
  assign dec_in_data_valid = valid_q;
  assign done              = done_q;
  assign seq_busy          = busy_q;
  assign error             = error_q;

endmodule

// File: tb/tb_decompressor_sequencer.sv
// Self-checking bench for decompressor_sequencer against a byte-stream parsing model.
module tb_decompressor_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, in_valid, in_last, dec_busy;
  logic [7:0]  in_byte;
  logic        in_ready, dec_control_word, dec_in_data_valid, seq_busy, done, error;
  logic [15:0] dec_data_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  src_q[$];
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  logic        exp_err;
  int          first_xfer, last_xfer, last_byte, done_cyc;

  decompressor_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .in_byte           (in_byte),
    .in_valid          (in_valid),
    .in_last           (in_last),
    .in_ready          (in_ready),
    .dec_data_in       (dec_data_in),
    .dec_control_word  (dec_control_word),
    .dec_in_data_valid (dec_in_data_valid),
    .dec_busy          (dec_busy),
    .seq_busy          (seq_busy),
    .done              (done),
    .error             (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input string tag);
    int w = 0;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_data"},     32'(dec_data_in), 32'h0000);
    check({tag, "_ctrl"},     32'(dec_control_word), 32'd0);
    check({tag, "_valid"},    32'(dec_in_data_valid), 32'd0);
    check({tag, "_busy"},     32'(seq_busy), 32'd0);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_error"},    32'(error), 32'd0);
  endtask

  // Parse the whole stream: control word, then one item per flag bit, LSB first.
  task automatic build_model();
    int          n = src_q.size();
    int          i = 0;
    logic [15:0] flags;
    exp_q.delete();
    exp_err = 1'b0;
    while (i < n) begin
      if (i == n - 1) break;
      flags = {src_q[i+1], src_q[i]};
      i += 2;
      for (int k = 0; k < 16 && i < n; k++) begin
        if (flags[k]) begin
          if (i == n - 1) begin
            exp_err = 1'b1;
            i = n;
          end else begin
            exp_q.push_back({1'b1, src_q[i], src_q[i+1]});
            i += 2;
          end
        end else begin
          exp_q.push_back({1'b0, 8'h00, src_q[i]});
          i += 1;
        end
      end
    end
  endtask

  task automatic run_stream(input int gap_pct, input int busy_pct, input string tag);
    int n   = src_q.size();
    int idx = 0;
    int exp_done;
    build_model();
    obs_q.delete();
    first_xfer = -1;
    last_xfer  = -1;
    last_byte  = -1;
    done_cyc   = -1;
    pulse_start();
    for (int k = 0; k < 4000; k++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start    = ($urandom_range(0, 99) < 5);
      dec_busy = ($urandom_range(0, 99) < busy_pct);
      if (idx < n && $urandom_range(0, 99) >= gap_pct) begin
        in_valid = 1'b1;
        in_byte  = src_q[idx];
        in_last  = (idx == n - 1);
      end else begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        in_last  = 1'($urandom);
      end
      if (in_valid && in_ready) begin
        idx++;
        last_byte = cyc;
      end
      if (dec_in_data_valid && !dec_busy) begin
        obs_q.push_back({dec_control_word, dec_data_in});
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
      end
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    dec_busy = 1'b0;
    check({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
    check({tag, "_n_items"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_item%0d", tag, i),
            (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_bytes_used"}, 32'(idx), 32'(n));
    exp_done = ((last_xfer > last_byte) ? last_xfer : last_byte) + 1;
    check({tag, "_done_time"}, 32'(done_cyc), 32'(exp_done));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(seq_busy), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    in_last  = 1'b0;
    dec_busy = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Sixteen literals in one group, issued every second cycle.
    src_q = {8'h00, 8'h00};
    for (int b = 8'h41; b <= 8'h50; b++) src_q.push_back(8'(b));
    run_stream(0, 0, "lit");
    check("lit_first", 32'(obs_q[0]), 32'h00041);
    check("lit_last", 32'(obs_q[15]), 32'h00050);
    check("lit_spacing", 32'(last_xfer - first_xfer), 32'd30);

    // Literal, copy, literal.
    src_q = {8'h02, 8'h00, 8'h61, 8'h12, 8'h34, 8'h62};
    run_stream(0, 0, "mixed");
    check("mixed_copy", 32'(obs_q[1]), 32'h11234);

    // Backpressure: item held stable while the decompressor is busy.
    dec_busy = 1'b1;
    pulse_start();
    send_byte(8'h00, 1'b0, "bp_lo");
    send_byte(8'h00, 1'b0, "bp_hi");
    send_byte(8'h77, 1'b1, "bp_lit");
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(dec_in_data_valid), 32'd1);
      check("bp_data", 32'(dec_data_in), 32'h0077);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    dec_busy = 1'b0;
    tick();
    check("bp_after_valid", 32'(dec_in_data_valid), 32'd0);
    check("bp_done", 32'(done), 32'd1);
    tick();

    // Seventeen literals spanning two control words.
    src_q = {8'h00, 8'h00};
    for (int b = 0; b < 16; b++) src_q.push_back(8'(8'h80 + b));
    src_q.push_back(8'h00);
    src_q.push_back(8'h00);
    src_q.push_back(8'hC3);
    run_stream(20, 30, "wrap");
    check("wrap_count", 32'(dut.u_flags.count_q), 32'd1);

    // Stream ends on the first byte of a copy.
    src_q = {8'h01, 8'h00, 8'hAB};
    run_stream(0, 0, "trunc");
    pulse_start();
    check("trunc_clear", 32'(error), 32'd0);
    send_byte(8'h00, 1'b1, "empty_lo");
    check("empty_done", 32'(done), 32'd1);
    tick();

    // Reset while waiting for the second byte of a copy.
    pulse_start();
    send_byte(8'h01, 1'b0, "rst_lo");
    send_byte(8'h00, 1'b0, "rst_hi");
    send_byte(8'hCD, 1'b0, "rst_copy_hi");
    check("rst_pre_busy", 32'(seq_busy), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_vals("rst_mid");
    reset = 1'b0;
    tick();
    src_q = {8'h02, 8'h00, 8'h61, 8'h12, 8'h34, 8'h62};
    run_stream(10, 20, "post_rst");

    // Arbitrary byte streams: every byte sequence is a legal or truncated stream.
    for (int r = 0; r < 8; r++) begin
      int len = $urandom_range(1, 48);
      src_q.delete();
      for (int b = 0; b < len; b++) src_q.push_back(8'($urandom));
      run_stream($urandom_range(0, 40), $urandom_range(0, 50), $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
